fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Instruction-fetch front end that owns the program counter and drives the synchronous instruction memory address. Selects the next PC from sequential, branch/jump redirect, exception entry and ERET return, and absorbs the memory's one-cycle read latency. Presents an aligned (PC, instruction, valid, address-error) bundle to the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_3000, boot address and low bound of the instruction space
HANDLER_PC, 32'h0000_4180, exception entry address
IM_TOP, 32'h0000_4FFC, highest legal word address (2048-word IM)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard stall from decode; hold PC and the IF bundle
br_redirect  in  1  branch/jump taken, resolved in ID
br_target  in  32  redirect target
exc_req  in  1  CP0 exception/interrupt entry
eret_req  in  1  ERET executing
epc  in  32  CP0 EPC, return address for ERET
im_addr  out  32  byte address to instruction memory (sampled on clk)
im_instr  in  32  memory read data, valid one cycle after im_addr
if_pc  out  32  PC of the instruction on if_instr
if_pc8  out  32  if_pc + 8 (link value)
if_instr  out  32  fetched instruction
if_valid  out  1  bundle is a real instruction
if_adel  out  1  fetch address error on if_pc

Behaviour:
- State: pc_q (32 bits), boot_q (1 bit). Reset: pc_q=RESET_PC, boot_q=1.
- im_addr = npc (combinational), so the memory output on the next cycle belongs to the new pc_q. if_instr = im_instr, or 0 when if_adel=1.
- BOOT (boot_q=1): npc=RESET_PC, pc_q held, if_valid=0. Leaves BOOT after exactly one clk edge; all requests in this cycle are ignored.
- RUN npc priority, highest first: exc_req -> HANDLER_PC; eret_req -> epc; stall -> pc_q; br_redirect -> br_target; otherwise pc_q+4, wrapping mod 2^32.
- exc_req and eret_req override stall. br_redirect during stall is ignored, and decode re-asserts it after the stall.
- squash = exc_req | eret_req | (br_redirect & ~stall) (delay-slot variant below). if_valid = ~boot_q & ~squash.
- if_adel = ~boot_q & (pc_q[1:0]!=0 | pc_q<RESET_PC | pc_q>IM_TOP). The memory is still addressed with the misaligned or out-of-range value, but the data is discarded (if_instr=0). if_valid is unaffected, so CP0 raises AdEL downstream.
- Stall: pc_q holds and im_addr=pc_q, so the memory re-reads the same word and if_instr stays stable.
- if_pc8 = pc_q+8, mod 2^32.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). The BOOT cycle repeats after release.
- Output values during and immediately after reset: if_pc=RESET_PC, if_valid=0, if_adel=0, im_addr=RESET_PC.

Optional Feature:
BRANCH_DELAY_SLOT_EN:
- Defined: br_redirect does not squash. The instruction in IF (the delay slot) stays valid, and the redirect takes effect on the following fetch.
- Undefined: the instruction in IF during br_redirect has if_valid=0.
- exc_req and eret_req always squash, in both variants.

Test Plan:
- Reset released, no stalls -> one cycle with if_valid=0, if_pc=0x3000; then if_pc=0x3000, 0x3004, 0x3008 with if_valid=1, and if_instr matches the preloaded IM words.
- stall high 3 cycles at if_pc=0x3008 -> if_pc and if_instr held for 3 cycles, im_addr=0x3008; then 0x300C.
- br_redirect with br_target=0x3040 at if_pc=0x3010 -> that cycle: if_valid=0 (macro off) or 1 (macro on); next: if_pc=0x3040, if_valid=1.
- exc_req together with stall at if_pc=0x3020 -> if_valid=0; next cycle if_pc=0x4180. Then eret_req with epc=0x3024 -> next if_pc=0x3024.
- Redirect to 0x3042, then to 0x5000 -> each gives if_adel=1, if_instr=0x00000000, if_valid=1.
- Reset pulsed asynchronously mid-stream at if_pc=0x3100 -> outputs return to reset values immediately; the BOOT cycle then repeats and fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end.
// Owns the program counter, selects the next fetch address, drives the
// synchronous instruction memory and presents an aligned IF bundle
// (pc, pc+8, instruction, valid, address error) to the IF/ID register.
// Optional build macro: BRANCH_DELAY_SLOT_EN. When it is defined, a taken
// branch/jump does not squash the instruction in IF, which becomes the delay
// slot. When it is undefined, that instruction is squashed.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_TOP     = 32'h0000_4FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc8,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        if_adel
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        boot_q;
  logic        boot_d;
  logic [31:0] npc;
  logic        squash;
  logic        addr_err;

  // Next-PC selection.
  // Exception and ERET override stall. A redirect seen during a stall is
  // dropped because decode re-asserts it once the stall clears.
  always_comb begin
    npc = pc_q + 32'd4;
    if (boot_q) begin
      npc = RESET_PC;
    end else if (exc_req) begin
      npc = HANDLER_PC;
    end else if (eret_req) begin
      npc = epc;
    end else if (stall) begin
      npc = pc_q;
    end else if (br_redirect) begin
      npc = br_target;
    end
    pc_d   = npc;
    boot_d = 1'b0;
  end

  // Squash of the instruction currently in IF.
  always_comb begin
`ifdef BRANCH_DELAY_SLOT_EN
    squash = exc_req | eret_req;
`else
    squash = exc_req | eret_req | (br_redirect & ~stall);
`endif
  end

  // Fetch address error: a misaligned PC, or a PC outside the instruction window.
  always_comb begin
    addr_err = 1'b0;
    if (!boot_q) begin
      addr_err = (pc_q[1:0] != 2'b00) | (pc_q < RESET_PC) | (pc_q > IM_TOP);
    end
  end

  // PC and boot flags. Reset is asynchronous so fetch restarts immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      boot_q <= 1'b1;
    end else begin
      pc_q   <= pc_d;
      boot_q <= boot_d;
    end
  end

  // The memory sees the next PC, so its data on the following cycle lines up
  // with pc_q. During a stall npc equals pc_q, so the same word is re-read.
  assign im_addr  = npc;
  assign if_pc    = pc_q;
  assign if_pc8   = pc_q + 32'd8;
  assign if_adel  = addr_err;
  assign if_instr = addr_err ? 32'h0000_0000 : im_instr;
  assign if_valid = ~boot_q & ~squash;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: self-checking bench for fetch_pc_unit.
// A behavioural model tracks the architectural PC sequence from the
// redirect priority rules and predicts each cycle's IF bundle.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_TOP     = 32'h0000_4FFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_redirect = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [31:0] im_addr;
  logic [31:0] im_instr = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_pc8;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_adel;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] imem [0:2047];
  logic [31:0] m_pc;
  bit          m_boot;

  fetch_pc_unit #(
    .RESET_PC  (RESET_PC),
    .HANDLER_PC(HANDLER_PC),
    .IM_TOP    (IM_TOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_redirect(br_redirect),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .im_addr    (im_addr),
    .im_instr   (im_instr),
    .if_pc      (if_pc),
    .if_pc8     (if_pc8),
    .if_instr   (if_instr),
    .if_valid   (if_valid),
    .if_adel    (if_adel)
  );

  always #5 clk = ~clk;

  // Word stored at a byte address. Outside the IM window the bus returns junk.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - RESET_PC;
    if (a >= RESET_PC && off < 32'h0000_2000) mem_word = imem[off[12:2]];
    else mem_word = a ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge clk) im_instr <= mem_word(im_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Predict this cycle's bundle from the model state and the current inputs,
  // compare it, then move the model to the next fetch.
  task automatic model_cycle();
    logic [31:0] npc;
    logic [31:0] exp_instr;
    bit          adel;
    bit          valid;
    bit          sq;
    if (m_boot) begin
      adel  = 0;
      valid = 0;
      npc   = RESET_PC;
    end else begin
      adel = (m_pc % 4 != 0) || (m_pc < RESET_PC) || (m_pc > IM_TOP);
`ifdef BRANCH_DELAY_SLOT_EN
      sq = exc_req || eret_req;
`else
      sq = exc_req || eret_req || (br_redirect && !stall);
`endif
      valid = !sq;
      if (exc_req)          npc = HANDLER_PC;
      else if (eret_req)    npc = epc;
      else if (stall)       npc = m_pc;
      else if (br_redirect) npc = br_target;
      else                  npc = m_pc + 32'd4;
    end
    check_eq("if_pc", if_pc, m_pc);
    check_eq("if_pc8", if_pc8, m_pc + 32'd8);
    check_eq("im_addr", im_addr, npc);
    check_eq("if_valid", {31'b0, if_valid}, {31'b0, valid});
    check_eq("if_adel", {31'b0, if_adel}, {31'b0, adel});
    if (!m_boot) begin
      exp_instr = adel ? 32'h0 : mem_word(m_pc);
      check_eq("if_instr", if_instr, exp_instr);
    end
    $display("t=%0t pc=%h instr=%h v=%0d adel=%0d st=%0d br=%0d exc=%0d eret=%0d",
             $time, if_pc, if_instr, if_valid, if_adel, stall, br_redirect, exc_req, eret_req);
    m_pc   = npc;
    m_boot = 0;
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] t,
                      input logic x, input logic r, input logic [31:0] e);
    @(negedge clk);
    stall = s; br_redirect = b; br_target = t; exc_req = x; eret_req = r; epc = e;
    #1;
    model_cycle();
  endtask

  // Reset pulsed at an arbitrary point inside a cycle; outputs must react at once.
  task automatic async_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    reset = 1'b1;
    stall = 0; br_redirect = 0; exc_req = 0; eret_req = 0;
    #1;
    check_eq("rst_if_pc", if_pc, RESET_PC);
    check_eq("rst_im_addr", im_addr, RESET_PC);
    check_eq("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_if_adel", {31'b0, if_adel}, 32'd0);
    $display("t=%0t async reset pc=%h v=%0d", $time, if_pc, if_valid);
    m_pc   = RESET_PC;
    m_boot = 1;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 8)       rand_addr = RESET_PC + 32'($urandom_range(0, 2047)) * 32'd4;
    else if (sel == 8) rand_addr = RESET_PC + 32'($urandom_range(0, 8191));
    else               rand_addr = $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) imem[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_if_pc", if_pc, RESET_PC);
    check_eq("rst_im_addr", im_addr, RESET_PC);
    check_eq("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_if_adel", {31'b0, if_adel}, 32'd0);
    #1 reset = 1'b0;
    m_pc   = RESET_PC;
    m_boot = 1;

    // Directed walk through the fetch scenarios.
    step(0, 0, 0, 0, 0, 0);                      // boot cycle
    step(0, 0, 0, 0, 0, 0);                      // 3000
    step(0, 0, 0, 0, 0, 0);                      // 3004
    step(1, 0, 0, 0, 0, 0);                      // 3008 stalled x3
    step(1, 1, 32'h0000_3FF0, 0, 0, 0);          // redirect ignored under stall
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);                      // 3008
    step(0, 0, 0, 0, 0, 0);                      // 300C
    step(0, 1, 32'h0000_3040, 0, 0, 0);          // 3010 redirect
    step(0, 1, 32'h0000_3020, 0, 0, 0);          // 3040 redirect
    step(1, 0, 0, 1, 0, 0);                      // 3020 exception + stall
    step(0, 0, 0, 0, 1, 32'h0000_3024);          // 4180 eret
    step(0, 1, 32'h0000_3042, 0, 0, 0);          // 3024 -> misaligned
    step(0, 1, 32'h0000_5000, 0, 0, 0);          // 3042 -> out of range
    step(0, 1, 32'h0000_4FFC, 0, 0, 0);          // 5000 -> top word
    step(0, 1, 32'h0000_2FFC, 0, 0, 0);          // 4FFC -> below window
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);          // 2FFC -> wrap point
    step(0, 0, 0, 0, 0, 0);                      // FFFFFFFC
    step(0, 1, 32'h0000_3100, 0, 0, 0);          // 0 -> 3100
    async_reset();                               // hit while at 3100
    step(0, 0, 0, 0, 0, 0);                      // boot again
    step(0, 0, 0, 0, 0, 0);                      // 3000
    step(0, 0, 0, 0, 0, 0);                      // 3004

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      if (c % 400 == 399) async_reset();
      step(($urandom % 4) == 0, ($urandom % 8) == 0, rand_addr(),
           ($urandom % 32) == 0, ($urandom % 32) == 0, rand_addr());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
